// File: rtl/sc_lanes_shifter.sv
// Multi-lane vehicle-row shifter: LANES independent WIDTH-bit bitmaps, each with its
// own speed divider, direction and rotate/zero-fill mode, plus a shared load bus.

module sc_lanes_lane #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             mode,
  input  logic [PW-1:0]    period,
  output logic [WIDTH-1:0] data_q,
  output logic             step_q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shifted;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             step_d;

  always_comb begin
    // mode gates the wrapped-around bit, so zero-fill is rotate with the carry masked
    if (dir) shifted = {mode & data_q[0], data_q[WIDTH-1:1]};
    else     shifted = {data_q[WIDTH-2:0], mode & data_q[WIDTH-1]};

    data_d = data_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (enable) begin
      // >= so a period lowered below the running count steps immediately
      if (cnt_q >= period) begin
        data_d = shifted;
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

endmodule

module sc_lanes_shifter #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int PW    = 4,
  parameter int SELW  = 2
) (
  input  logic                   SC_LANES_CLOCK,
  input  logic                   SC_LANES_RESET,
  input  logic                   SC_LANES_ENABLE,
  input  logic                   SC_LANES_LOAD,
  input  logic [SELW-1:0]        SC_LANES_LOAD_SEL,
  input  logic [WIDTH-1:0]       SC_LANES_LOAD_DATA,
  input  logic [LANES-1:0]       SC_LANES_DIR,
  input  logic [LANES-1:0]       SC_LANES_MODE,
  input  logic [LANES*PW-1:0]    SC_LANES_PERIOD,
  output logic [LANES*WIDTH-1:0] SC_LANES_DATA_OUT,
  output logic [LANES-1:0]       SC_LANES_STEP
);

  logic [LANES-1:0][WIDTH-1:0] lane_data;
  logic [LANES-1:0]            lane_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // out-of-range selects match no lane, so those loads fall away
    assign lane_load[i] = SC_LANES_LOAD && (SC_LANES_LOAD_SEL == SELW'(i));

    sc_lanes_lane #(.WIDTH(WIDTH), .PW(PW)) u_lane (
      .clk       (SC_LANES_CLOCK),
      .rst       (SC_LANES_RESET),
      .enable    (SC_LANES_ENABLE),
      .load      (lane_load[i]),
      .load_data (SC_LANES_LOAD_DATA),
      .dir       (SC_LANES_DIR[i]),
      .mode      (SC_LANES_MODE[i]),
      .period    (SC_LANES_PERIOD[i*PW +: PW]),
      .data_q    (lane_data[i]),
      .step_q    (SC_LANES_STEP[i])
    );
  end

  assign SC_LANES_DATA_OUT = lane_data;

endmodule
